booth_r4_mult_seq: RTL

//  Iterative radix-4 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH product, one Booth digit per clock.

---
 rtl/booth_pkg.sv | 23 ++
 rtl/booth_digit_enc.sv | 20 ++
 rtl/booth_r4_mult_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and radix-4 Booth digit encoding constants for booth_r4_mult_seq.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed Booth digit as magnitude flags plus sign: value = (neg ? -1 : 1) * (two ? 2 : one ? 1 : 0)
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } digit_t;

    localparam digit_t DIG_ZERO = 3'b000;
    localparam digit_t DIG_POS1 = 3'b010;
    localparam digit_t DIG_POS2 = 3'b001;
    localparam digit_t DIG_NEG1 = 3'b110;
    localparam digit_t DIG_NEG2 = 3'b101;

endpackage

// File: rtl/booth_digit_enc.sv
// Combinational radix-4 Booth recoder: triplet {b[2i+1], b[2i], b[2i-1]} -> signed digit flags.
module booth_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0] triplet,
    output digit_t     digit_c
);

    always_comb begin
        digit_c = DIG_ZERO;
        case (triplet)
            3'b001, 3'b010: digit_c = DIG_POS1;
            3'b011:         digit_c = DIG_POS2;
            3'b100:         digit_c = DIG_NEG2;
            3'b101, 3'b110: digit_c = DIG_NEG1;
            default:        digit_c = DIG_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_mult_seq.sv
// Iterative signed radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Define BOOTH_MULT_ACC_EN to add the acc port and compute p = a*b + acc (MAC).
module booth_r4_mult_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef BOOTH_MULT_ACC_EN
    input  logic [2*WIDTH-1:0]   acc,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned DIGITS = WIDTH / 2;
    localparam int unsigned CNT_W  = $clog2(DIGITS) + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    a_ext;
    logic [WIDTH:0]   b_ext;
    logic [PW-1:0]    sum;

    logic [CNT_W:0]   tri_lsb;
    logic [2:0]       triplet;
    digit_t           digit_c;
    logic [PW-1:0]    a_sh;
    logic [PW-1:0]    pp;
    logic [PW-1:0]    sum_nxt;

    // b_ext[0] is the implicit b[-1]=0, so digit i reads b_ext[2i+2:2i]
    assign tri_lsb = {cnt, 1'b0};
    assign triplet = b_ext[tri_lsb +: 3];

    booth_digit_enc u_enc (
        .triplet (triplet),
        .digit_c (digit_c)
    );

    // Partial product d*a<<(2i), wrapping modulo 2^PW
    assign a_sh    = a_ext << tri_lsb;
    assign pp      = digit_c.two ? (a_sh << 1) : (digit_c.one ? a_sh : '0);
    assign sum_nxt = digit_c.neg ? (sum - pp) : (sum + pp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_ext     <= '0;
            b_ext     <= '0;
            sum       <= '0;
            p         <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_ext    <= PW'($signed(a));
                        b_ext    <= {b, 1'b0};
`ifdef BOOTH_MULT_ACC_EN
                        sum      <= acc;
`else
                        sum      <= '0;
`endif
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    sum <= sum_nxt;
                    if (cnt == CNT_W'(DIGITS - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        p         <= sum_nxt;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
